// File: rtl/skintone_classifier_pipe.sv
// -----------------------------------------------------------------------------
// skintone_classifier_pipe
//
// Multi-lane RGB skin-tone classifier with a stall-as-a-whole pipeline.
// Each lane converts RGB to BT.601 chroma (Cb, Cr), clamps it to the CW-bit
// range and flags the pixel as skin when both components sit inside the
// programmable inclusive windows. A saturating counter tallies skin lanes
// that leave the block.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pixel_datain             LANES x {R,G,B}, lane k at [3*CW*(k+1)-1 : 3*CW*k]
//   pixel_datain_valid/ready input handshake (ready = pipe may advance)
//   cb_min/cb_max/cr_min/cr_max  inclusive chroma windows, sampled at stage 3
//   result_dataout           LANES bytes, 8'hFF = skin, 8'h00 = not skin
//   result_dataout_valid/ready   output handshake
//   count_clear              synchronous clear of skin_pixel_count
//   skin_pixel_count         saturating count of transferred skin lanes
//
// Pipeline: stage 1 = products, stage 2 = shift/offset/clamp, stage 3 =
// window compare, stages 4..STAGES = delay. Output is the last stage.
// -----------------------------------------------------------------------------
module skintone_classifier_pipe #(
   parameter int CW     = 8,
   parameter int LANES  = 1,
   parameter int STAGES = 16,
   parameter int CNT_W  = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [3*CW*LANES-1:0]   pixel_datain,
   input  logic                    pixel_datain_valid,
   output logic                    pixel_datain_ready,
   input  logic [CW-1:0]           cb_min,
   input  logic [CW-1:0]           cb_max,
   input  logic [CW-1:0]           cr_min,
   input  logic [CW-1:0]           cr_max,
   output logic [8*LANES-1:0]      result_dataout,
   output logic                    result_dataout_valid,
   input  logic                    result_dataout_ready,
   input  logic                    count_clear,
   output logic [CNT_W-1:0]        skin_pixel_count
);

   localparam int PW  = CW + 10;
   localparam int PCW = $clog2(LANES + 1);
   localparam int SKN = STAGES - 2;   // skin registers: stage 3 .. STAGES

   localparam logic signed [PW-1:0] K21   = PW'(21);
   localparam logic signed [PW-1:0] K43   = PW'(43);
   localparam logic signed [PW-1:0] K85   = PW'(85);
   localparam logic signed [PW-1:0] K107  = PW'(107);
   localparam logic signed [PW-1:0] K128  = PW'(128);
   localparam logic signed [PW-1:0] HALF  = PW'(2 ** (CW - 1));
   localparam logic signed [PW-1:0] MAXV  = PW'(2 ** CW - 1);

   logic                  advance;
   logic [STAGES-1:0]     vld_q;          // bit i = valid of stage i+1
   logic [LANES-1:0]      skin_d;
   logic [LANES-1:0]      skin_q [SKN];   // [0] = stage 3, [SKN-1] = output
   logic [PCW-1:0]        pop_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_base;
   logic [CNT_W:0]        cnt_sum;
   logic                  xfer;

   // Floor shift by 8, recentre, then clamp into [0, 2^CW-1].
   function automatic logic [CW-1:0] clamp_chroma(input logic signed [PW-1:0] s);
      logic signed [PW-1:0] t;
      t = (s >>> 8) + HALF;
      if (t[PW-1])
         return '0;
      else if (t > MAXV)
         return '1;
      else
         return t[CW-1:0];
   endfunction

   assign advance              = !result_dataout_valid || result_dataout_ready;
   assign pixel_datain_ready   = advance;
   assign result_dataout_valid = vld_q[STAGES-1];

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [CW-1:0]        r_w, g_w, b_w;
         logic signed [PW-1:0] r_s, g_s, b_s;
         logic signed [PW-1:0] cbs_d, crs_d, cbs_q, crs_q;
         logic [CW-1:0]        cb_d, cr_d, cb_q, cr_q;

         assign r_w = pixel_datain[3*CW*gi + 2*CW +: CW];
         assign g_w = pixel_datain[3*CW*gi + CW   +: CW];
         assign b_w = pixel_datain[3*CW*gi        +: CW];
         assign r_s = $signed({{(PW-CW){1'b0}}, r_w});
         assign g_s = $signed({{(PW-CW){1'b0}}, g_w});
         assign b_s = $signed({{(PW-CW){1'b0}}, b_w});

         assign cbs_d = K128 * b_s - K43 * r_s - K85 * g_s;
         assign crs_d = K128 * r_s - K107 * g_s - K21 * b_s;
         assign cb_d  = clamp_chroma(cbs_q);
         assign cr_d  = clamp_chroma(crs_q);

         // Empty windows (min > max) fail both compares naturally.
         assign skin_d[gi] = (cb_q >= cb_min) && (cb_q <= cb_max) &&
                             (cr_q >= cr_min) && (cr_q <= cr_max);

         always_ff @(posedge clk) begin
            if (advance) begin
               cbs_q <= cbs_d;
               crs_q <= crs_d;
               cb_q  <= cb_d;
               cr_q  <= cr_d;
            end
         end

         assign result_dataout[8*gi +: 8] = {8{skin_q[SKN-1][gi]}};
      end
   endgenerate

   // Valid bits and skin flags; skin flags are reset so the output byte
   // reads zero out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         for (int i = 0; i < SKN; i++)
            skin_q[i] <= '0;
      end else if (advance) begin
         vld_q     <= {vld_q[STAGES-2:0], pixel_datain_valid};
         skin_q[0] <= skin_d;
         for (int i = 1; i < SKN; i++)
            skin_q[i] <= skin_q[i-1];
      end
   end

   // Skin-lane counter: clear acts as a zero base, so clear+transfer loads
   // the beat's popcount; the extra carry bit detects saturation.
   always_comb begin
      pop_d = '0;
      for (int i = 0; i < LANES; i++)
         pop_d = pop_d + PCW'(skin_q[SKN-1][i]);
      xfer     = result_dataout_valid && result_dataout_ready;
      cnt_base = count_clear ? '0 : cnt_q;
      cnt_sum  = {1'b0, cnt_base} + (CNT_W+1)'(pop_d);
      cnt_d    = cnt_base;
      if (xfer)
         cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign skin_pixel_count = cnt_q;

endmodule

// File: tb/tb_skintone_classifier_pipe.sv
// -----------------------------------------------------------------------------
// tb_skintone_classifier_pipe
//
// Directed bench for skintone_classifier_pipe, configured CW=8, LANES=4,
// STAGES=16, CNT_W=4. Beats are built from a 4-bit lane mask: a set bit puts
// the skin pixel (200,150,120) in that lane, a clear bit puts black (0,0,0).
// -----------------------------------------------------------------------------
module tb_skintone_classifier_pipe;

   localparam int CW      = 8;
   localparam int LANES   = 4;
   localparam int STAGES  = 16;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = 15;
   localparam logic [23:0] SKIN_PIX = 24'hC89678;   // (200,150,120)

   logic                  clk = 1'b0;
   logic                  rst;
   logic [3*CW*LANES-1:0] pixel_datain;
   logic                  pixel_datain_valid;
   logic                  pixel_datain_ready;
   logic [CW-1:0]         cb_min, cb_max, cr_min, cr_max;
   logic [8*LANES-1:0]    result_dataout;
   logic                  result_dataout_valid;
   logic                  result_dataout_ready;
   logic                  count_clear;
   logic [CNT_W-1:0]      skin_pixel_count;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_count = 0;
   logic [3:0] masks[$];

   always #5 clk = ~clk;

   skintone_classifier_pipe #(
      .CW(CW), .LANES(LANES), .STAGES(STAGES), .CNT_W(CNT_W)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .pixel_datain         (pixel_datain),
      .pixel_datain_valid   (pixel_datain_valid),
      .pixel_datain_ready   (pixel_datain_ready),
      .cb_min               (cb_min),
      .cb_max               (cb_max),
      .cr_min               (cr_min),
      .cr_max               (cr_max),
      .result_dataout       (result_dataout),
      .result_dataout_valid (result_dataout_valid),
      .result_dataout_ready (result_dataout_ready),
      .count_clear          (count_clear),
      .skin_pixel_count     (skin_pixel_count)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3*CW*LANES-1:0] beat_of(input logic [3:0] mask);
      logic [3*CW*LANES-1:0] b;
      b = '0;
      for (int k = 0; k < LANES; k++)
         if (mask[k]) b[24*k +: 24] = SKIN_PIX;
      return b;
   endfunction

   function automatic logic [8*LANES-1:0] exp_of(input logic [3:0] mask);
      logic [8*LANES-1:0] r;
      r = '0;
      for (int k = 0; k < LANES; k++)
         if (mask[k]) r[8*k +: 8] = 8'hFF;
      return r;
   endfunction

   function automatic int sat_add(input int a, input int b);
      return (a + b > CNT_MAX) ? CNT_MAX : a + b;
   endfunction

   // Send one beat into an idle pipe with the sink ready, measure latency,
   // check the result and the count after the output transfer.
   task automatic send_single(input string tag, input logic [3*CW*LANES-1:0] beat,
                              input logic [8*LANES-1:0] exp_res, input int pop);
      int lat;
      result_dataout_ready = 1'b1;
      pixel_datain         = beat;
      pixel_datain_valid   = 1'b1;
      #1;
      check_eq({tag, "_in_ready"}, 64'(pixel_datain_ready), 64'd1);
      tick();
      pixel_datain_valid = 1'b0;
      lat = 1;
      while (!result_dataout_valid && lat < 40) begin
         tick();
         lat++;
      end
      check_eq({tag, "_latency"}, 64'(lat), 64'(STAGES));
      check_eq({tag, "_result"}, 64'(result_dataout), 64'(exp_res));
      $display("%s: result=%08h latency=%0d", tag, result_dataout, lat);
      tick();
      exp_count = sat_add(exp_count, pop);
      check_eq({tag, "_valid_drop"}, 64'(result_dataout_valid), 64'd0);
      check_eq({tag, "_count"}, 64'(skin_pixel_count), 64'(exp_count));
   endtask

   // Expect no output valid for a number of cycles.
   task automatic expect_idle(input string tag, input int cycles);
      int stale = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (result_dataout_valid) stale++;
      end
      check_eq(tag, 64'(stale), 64'd0);
   endtask

   // Stream the beats in 'masks'; ready follows 1,0,0,1,0,0... when toggle=1.
   task automatic run_stream(input string tag, input bit toggle);
      int n, sent, recv, cyc;
      bit hold_pend;
      logic [8*LANES-1:0] held;
      n = masks.size();
      sent = 0; recv = 0; cyc = 0; hold_pend = 1'b0; held = '0;
      while (recv < n && cyc < 2000) begin
         if (hold_pend) begin
            check_eq({tag, "_hold_valid"}, 64'(result_dataout_valid), 64'd1);
            check_eq({tag, "_hold_data"}, 64'(result_dataout), 64'(held));
         end
         result_dataout_ready = toggle ? (cyc % 3 == 0) : 1'b1;
         if (sent < n) begin
            pixel_datain_valid = 1'b1;
            pixel_datain       = beat_of(masks[sent]);
         end else begin
            pixel_datain_valid = 1'b0;
         end
         #1;
         check_eq({tag, "_in_ready"}, 64'(pixel_datain_ready),
                  64'(!(result_dataout_valid && !result_dataout_ready)));
         hold_pend = result_dataout_valid && !result_dataout_ready;
         held      = result_dataout;
         if (result_dataout_valid && result_dataout_ready) begin
            check_eq({tag, "_data"}, 64'(result_dataout), 64'(exp_of(masks[recv])));
            $display("%s: beat %0d result=%08h", tag, recv, result_dataout);
            exp_count = sat_add(exp_count, $countones(masks[recv]));
            recv++;
         end
         if (pixel_datain_valid && pixel_datain_ready) sent++;
         tick();
         cyc++;
      end
      pixel_datain_valid   = 1'b0;
      result_dataout_ready = 1'b1;
      check_eq({tag, "_received"}, 64'(recv), 64'(n));
      check_eq({tag, "_count"}, 64'(skin_pixel_count), 64'(exp_count));
      expect_idle({tag, "_no_extra"}, 20);
   endtask

   task automatic clear_count();
      count_clear = 1'b1;
      tick();
      count_clear = 1'b0;
      exp_count = 0;
      check_eq("clear_count", 64'(skin_pixel_count), 64'd0);
   endtask

   initial begin
      int w;
      rst = 1'b1;
      pixel_datain = '0;
      pixel_datain_valid = 1'b0;
      result_dataout_ready = 1'b1;
      count_clear = 1'b0;
      cb_min = 8'd77;  cb_max = 8'd127;
      cr_min = 8'd133; cr_max = 8'd173;
      repeat (3) tick();
      rst = 1'b0;
      #1;
      check_eq("rst_valid", 64'(result_dataout_valid), 64'd0);
      check_eq("rst_result", 64'(result_dataout), 64'd0);
      check_eq("rst_count", 64'(skin_pixel_count), 64'd0);
      check_eq("rst_in_ready", 64'(pixel_datain_ready), 64'd1);

      // Single pixels on lane 0 (other lanes black).
      send_single("skin_200_150_120", {72'h0, 24'hC89678}, 32'h000000FF, 1);
      send_single("black", {72'h0, 24'h000000}, 32'h00000000, 0);
      send_single("blue", {72'h0, 24'h0000FF}, 32'h00000000, 0);

      // Four lanes: lane0 skin, lane1 black, lane2 skin, lane3 skin.
      send_single("lanes_1101", beat_of(4'b1101), 32'hFFFF00FF, 3);

      // Empty Cb window: nothing is skin.
      cb_min = 8'd200; cb_max = 8'd100;
      send_single("empty_window", beat_of(4'b1111), 32'h00000000, 0);
      cb_min = 8'd77;  cb_max = 8'd127;

      // Saturation: 20 single-skin beats back to back.
      clear_count();
      masks.delete();
      for (int i = 0; i < 20; i++) masks.push_back(4'b0001);
      run_stream("saturate", 1'b0);

      // Backpressure stream with varying lane patterns.
      clear_count();
      masks.delete();
      for (int i = 0; i < 40; i++) masks.push_back(4'(i % 16));
      run_stream("stall_stream", 1'b1);

      // Clear coinciding with a one-skin transfer loads 1.
      result_dataout_ready = 1'b0;
      pixel_datain = beat_of(4'b0001);
      pixel_datain_valid = 1'b1;
      tick();
      pixel_datain_valid = 1'b0;
      w = 0;
      while (!result_dataout_valid && w < 40) begin
         tick();
         w++;
      end
      check_eq("clr_wait_valid", 64'(result_dataout_valid), 64'd1);
      check_eq("clr_stall_in_ready", 64'(pixel_datain_ready), 64'd0);
      check_eq("clr_count_before", 64'(skin_pixel_count), 64'(exp_count));
      count_clear = 1'b1;
      result_dataout_ready = 1'b1;
      tick();
      count_clear = 1'b0;
      exp_count = 1;
      check_eq("clr_with_xfer", 64'(skin_pixel_count), 64'd1);
      $display("clear_with_transfer: count=%0d", skin_pixel_count);

      // Reset with 5 beats in flight.
      for (int i = 0; i < 5; i++) begin
         pixel_datain = beat_of(4'b1111);
         pixel_datain_valid = 1'b1;
         tick();
      end
      pixel_datain_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_count = 0;
      check_eq("midrst_valid", 64'(result_dataout_valid), 64'd0);
      check_eq("midrst_count", 64'(skin_pixel_count), 64'd0);
      expect_idle("midrst_no_stale", STAGES);
      check_eq("midrst_count_after", 64'(skin_pixel_count), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/skintone_classifier_pipe.md
Name: skintone_classifier_pipe

Overview:
Parametrised multi-lane pixel classifier with full valid/ready backpressure. Each lane converts an RGB pixel to BT.601 chroma (Cb, Cr) and flags it as skin when both components fall inside programmable inclusive windows. The datapath is a STAGES-deep pipeline that stalls as a whole. The block sits between the pixel source and the result sink, and keeps a saturating count of skin pixels for software.

Parameters:
CW, 8, bits per colour channel (R, G, B); 8..12
LANES, 1, pixels processed per beat; 1..4
STAGES, 16, pipeline depth in cycles; minimum 3
CNT_W, 32, width of skin_pixel_count

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
pixel_datain  input  3*CW*LANES  lane k at [3*CW*(k+1)-1 : 3*CW*k], packed {R,G,B} with R in the MSBs
pixel_datain_valid  input  1  input beat valid
pixel_datain_ready  output  1  block accepts a beat this cycle
cb_min, cb_max, cr_min, cr_max  input  CW each  inclusive chroma window; quasi-static
result_dataout  output  8*LANES  lane k byte: 8'hFF = skin, 8'h00 = not skin
result_dataout_valid  output  1  output beat valid
result_dataout_ready  input  1  sink accepts the beat
count_clear  input  1  synchronous clear of skin_pixel_count
skin_pixel_count  output  CNT_W  running count of accepted skin pixels

Behaviour:
- One clock (clk). rst is synchronous and active-high.
- Reset: all stage valid bits = 0, result_dataout_valid = 0, result_dataout = 0, skin_pixel_count = 0. Data registers need not be reset.
- advance = !result_dataout_valid || result_dataout_ready. pixel_datain_ready = advance (combinational). pixel_datain_ready stays 1 while the pipe is empty.
- When advance = 1, every stage register and its valid bit shift by one, and stage 0 loads pixel_datain with valid = pixel_datain_valid. When advance = 0, all stages hold.
- Bubbles are not collapsed.
- Latency: exactly STAGES cycles from acceptance to result_dataout_valid when there is no stall. Throughput is one beat per cycle.
- result_dataout and result_dataout_valid are held stable while valid=1 and ready=0.
- Stage 1 (multiply): cbs = -43*R - 85*G + 128*B, crs = 128*R - 107*G - 21*B. Both are signed, width CW+10.
- Stage 2: each sum is arithmetically shifted right by 8 (floor), then 2^(CW-1) is added. The result is clamped to [0, 2^CW-1] to give Cb and Cr.
- Stage 3: skin = (cb_min <= Cb <= cb_max) && (cr_min <= Cr <= cr_max), all unsigned. If min > max, that window is empty and the lane is never skin.
- Stages 4..STAGES are pure delay (valid and data).
- Counter: increments by the number of skin lanes in a beat, on the cycle that beat is transferred at the output (valid && ready).
  - The counter saturates at 2^CNT_W-1 and does not wrap.
  - If count_clear and a transfer occur in the same cycle, the counter loads that beat's skin-lane count.
  - rst takes precedence over everything.
- Reset mid-operation: all in-flight beats are discarded, with no output transfer in the cycle after rst. Window ports are sampled at stage 3 each cycle, so changing them mid-stream affects only beats that have not yet passed stage 3.

Test Plan:
- CW=8, windows Cb 77..127 and Cr 133..173, RGB (200,150,120) sent once with ready held 1 → Cb=104, Cr=155; result 8'hFF with valid exactly 16 cycles after acceptance; count=1.
- RGB (0,0,0) gives Cb=128, Cr=128 → 8'h00. RGB (0,0,255) gives Cb=255, Cr=107 → 8'h00. Count is unchanged.
- Stream of 40 skin pixels with result_dataout_ready toggling 1,0,0,1,… → 40 results in order, none dropped or duplicated. Data is held during stalls, and pixel_datain_ready = 0 whenever the output is valid and ready = 0.
- LANES=4, beat = {skin, non-skin, skin, skin} → result 32'hFFFF00FF mapped by lane, count += 3. Set cb_min=200, cb_max=100 → all lanes 8'h00.
- CNT_W=4, 20 skin pixels → count saturates at 15. Assert count_clear during a 1-skin transfer → count = 1.
- Assert rst with 5 beats in flight → valid drops the next cycle, count = 0, and no stale beat appears in the following 16 cycles.
